// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: shared TAP definitions.
//   tap_state_e   - 4-bit TAP state codes (IEEE 1149.1 encoding used by the
//                   previous generated core, so state dumps stay comparable)
//   OP_*          - fixed opcodes; user data register k decodes at OP_TDR_BASE+k
package jtag_tap_pkg;

   typedef enum logic [3:0] {
      TLR    = 4'hF,
      RTI    = 4'hC,
      SEL_DR = 4'h7,
      CAP_DR = 4'h6,
      SH_DR  = 4'h2,
      EX1_DR = 4'h1,
      PA_DR  = 4'h3,
      EX2_DR = 4'h0,
      UPD_DR = 4'h5,
      SEL_IR = 4'h4,
      CAP_IR = 4'hE,
      SH_IR  = 4'hA,
      EX1_IR = 4'h9,
      PA_IR  = 4'hB,
      EX2_IR = 4'h8,
      UPD_IR = 4'hD
   } tap_state_e;

   localparam int unsigned OP_BYPASS   = 0;
   localparam int unsigned OP_IDCODE   = 1;
   localparam int unsigned OP_TDR_BASE = 2;

endpackage

// File: rtl/jtag_tap_param_if.sv
// jtag_tap_param_if: pin-wrapper / user-logic side of the TAP.
//   tms, tdi, tdr_in                 - into the TAP
//   tdo, tdo_en, tdr_out, *_stb,
//   state, instruction, in_tlr       - out of the TAP
// slave = TAP side, master = wrapper/user-logic side.
interface jtag_tap_param_if #(
   parameter int unsigned IR_W    = 4,
   parameter int unsigned NUM_TDR = 3,
   parameter int unsigned TDR_W   = 8
);
   logic                     tms;
   logic                     tdi;
   logic                     tdo;
   logic                     tdo_en;
   logic [NUM_TDR*TDR_W-1:0] tdr_in;
   logic [NUM_TDR*TDR_W-1:0] tdr_out;
   logic [NUM_TDR-1:0]       capture_stb;
   logic [NUM_TDR-1:0]       update_stb;
   logic [3:0]               state;
   logic [IR_W-1:0]          instruction;
   logic                     in_tlr;

   modport master (
      output tms, tdi, tdr_in,
      input  tdo, tdo_en, tdr_out, capture_stb, update_stb, state, instruction, in_tlr
   );

   modport slave (
      input  tms, tdi, tdr_in,
      output tdo, tdo_en, tdr_out, capture_stb, update_stb, state, instruction, in_tlr
   );
endinterface

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP controller.
//   clk, rst   - TCK and async active-high reset (resets to TLR)
//   tms        - test mode select
//   state      - current state; state_nxt - state after this edge
//   tlr, cap_*, sh_*, upd_* - decoded flags of the current state
module jtag_tap_fsm
   import jtag_tap_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tms,
   output tap_state_e state,
   output tap_state_e state_nxt,
   output logic       tlr,
   output logic       cap_dr,
   output logic       sh_dr,
   output logic       upd_dr,
   output logic       cap_ir,
   output logic       sh_ir,
   output logic       upd_ir
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= TLR;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = TLR;
      case (state)
         TLR:    state_nxt = tms ? TLR    : RTI;
         RTI:    state_nxt = tms ? SEL_DR : RTI;
         SEL_DR: state_nxt = tms ? SEL_IR : CAP_DR;
         CAP_DR: state_nxt = tms ? EX1_DR : SH_DR;
         SH_DR:  state_nxt = tms ? EX1_DR : SH_DR;
         EX1_DR: state_nxt = tms ? UPD_DR : PA_DR;
         PA_DR:  state_nxt = tms ? EX2_DR : PA_DR;
         EX2_DR: state_nxt = tms ? UPD_DR : SH_DR;
         UPD_DR: state_nxt = tms ? SEL_DR : RTI;
         SEL_IR: state_nxt = tms ? TLR    : CAP_IR;
         CAP_IR: state_nxt = tms ? EX1_IR : SH_IR;
         SH_IR:  state_nxt = tms ? EX1_IR : SH_IR;
         EX1_IR: state_nxt = tms ? UPD_IR : PA_IR;
         PA_IR:  state_nxt = tms ? EX2_IR : PA_IR;
         EX2_IR: state_nxt = tms ? UPD_IR : SH_IR;
         UPD_IR: state_nxt = tms ? SEL_DR : RTI;
         default: state_nxt = TLR;
      endcase
   end

   assign tlr    = (state == TLR);
   assign cap_dr = (state == CAP_DR);
   assign sh_dr  = (state == SH_DR);
   assign upd_dr = (state == UPD_DR);
   assign cap_ir = (state == CAP_IR);
   assign sh_ir  = (state == SH_IR);
   assign upd_ir = (state == UPD_IR);

endmodule

// File: rtl/jtag_tap_param.sv
// jtag_tap_param: parametrised 1149.1 TAP with IR, BYPASS, IDCODE and
// NUM_TDR user data registers of TDR_W bits.
//   clk, rst - TCK, async active-high reset
//   bus      - slave modport: tms/tdi/tdr_in in; tdo, tdo_en, tdr_out,
//              capture_stb, update_stb, state, instruction, in_tlr out
module jtag_tap_param
   import jtag_tap_pkg::*;
#(
   parameter int unsigned IR_W           = 4,
   parameter int unsigned NUM_TDR        = 3,
   parameter int unsigned TDR_W          = 8,
   parameter logic [31:0] IDCODE_VAL     = 32'h1000_0001,
   parameter bit          TLR_CLEARS_TDR = 1'b0
) (
   input logic               clk,
   input logic               rst,
   jtag_tap_param_if.slave   bus
);

   localparam int unsigned DR_W = (TDR_W > 32) ? TDR_W : 32;
   localparam int unsigned DW   = $clog2(DR_W);

   tap_state_e st, st_nxt;
   logic f_tlr, f_cap_dr, f_sh_dr, f_upd_dr, f_cap_ir, f_sh_ir, f_upd_ir;

   jtag_tap_fsm u_fsm (
      .clk       (clk),
      .rst       (rst),
      .tms       (bus.tms),
      .state     (st),
      .state_nxt (st_nxt),
      .tlr       (f_tlr),
      .cap_dr    (f_cap_dr),
      .sh_dr     (f_sh_dr),
      .upd_dr    (f_upd_dr),
      .cap_ir    (f_cap_ir),
      .sh_ir     (f_sh_ir),
      .upd_ir    (f_upd_ir)
   );

   logic [IR_W-1:0]               ir_sr, instr;
   logic [DR_W-1:0]               dr_sr, dr_cap, dr_shift;
   logic [DW-1:0]                 msb;      // L-1 of the selected register
   logic [NUM_TDR-1:0][TDR_W-1:0] tdr_q;
   logic [NUM_TDR-1:0]            sel_tdr, upd_stb_q;
   logic                          sel_idcode;

   // Instruction decode; unlisted codes (including all-ones) fall to BYPASS.
   always_comb begin
      sel_tdr = '0;
      for (int k = 0; k < NUM_TDR; k++)
         sel_tdr[k] = (instr == IR_W'(OP_TDR_BASE + k)) && (instr != '1);
      sel_idcode = (instr == IR_W'(OP_IDCODE));
   end

   // Capture value and active length; BYPASS is the all-zero default.
   always_comb begin
      dr_cap = '0;
      msb    = '0;
      if (sel_idcode) begin
         dr_cap = DR_W'(IDCODE_VAL);
         msb    = DW'(31);
      end
      for (int k = 0; k < NUM_TDR; k++) begin
         if (sel_tdr[k]) begin
            dr_cap = DR_W'(bus.tdr_in[k*TDR_W +: TDR_W]);
            msb    = DW'(TDR_W - 1);
         end
      end
   end

   // tdi enters at bit L-1; bits above that are don't-care.
   always_comb begin
      dr_shift      = {1'b0, dr_sr[DR_W-1:1]};
      dr_shift[msb] = bus.tdi;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_sr     <= '0;
         instr     <= IR_W'(OP_IDCODE);
         dr_sr     <= '0;
         tdr_q     <= '0;
         upd_stb_q <= '0;
      end else begin
         upd_stb_q <= '0;

         if (f_cap_ir)     ir_sr <= IR_W'(1);
         else if (f_sh_ir) ir_sr <= {bus.tdi, ir_sr[IR_W-1:1]};

         // Load IDCODE on the edge entering TLR so it is visible with the state.
         if (st_nxt == TLR) instr <= IR_W'(OP_IDCODE);
         else if (f_upd_ir) instr <= ir_sr;

         if (f_cap_dr)     dr_sr <= dr_cap;
         else if (f_sh_dr) dr_sr <= dr_shift;

         if (TLR_CLEARS_TDR && st_nxt == TLR) begin
            tdr_q <= '0;
         end else if (f_upd_dr) begin
            for (int k = 0; k < NUM_TDR; k++) begin
               if (sel_tdr[k]) begin
                  tdr_q[k]     <= dr_sr[TDR_W-1:0];
                  upd_stb_q[k] <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.tdo         = f_sh_dr ? dr_sr[0] : (f_sh_ir ? ir_sr[0] : 1'b0);
   assign bus.tdo_en      = f_sh_dr | f_sh_ir;
   assign bus.tdr_out     = tdr_q;
   assign bus.capture_stb = f_cap_dr ? sel_tdr : '0;
   assign bus.update_stb  = upd_stb_q;
   assign bus.state       = st;
   assign bus.instruction = instr;
   assign bus.in_tlr      = f_tlr;

endmodule

// File: tb/tb_jtag_tap_param.sv
// tb_jtag_tap_param: directed bench for jtag_tap_param. Two instances share
// stimulus; u_dut0 keeps tdr_out across TLR, u_dut1 clears it.
module tb_jtag_tap_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tms = 1'b1;
   logic        tdi = 1'b0;
   logic [23:0] tdr_in = 24'h77_A5_11;   // ch2=77, ch1=A5, ch0=11

   int checks = 0;
   int errors = 0;
   logic [63:0] sb_q[$];

   always #5 clk = ~clk;

   jtag_tap_param_if #(.IR_W(4), .NUM_TDR(3), .TDR_W(8)) bus0 ();
   jtag_tap_param_if #(.IR_W(4), .NUM_TDR(3), .TDR_W(8)) bus1 ();

   assign bus0.tms = tms;  assign bus0.tdi = tdi;  assign bus0.tdr_in = tdr_in;
   assign bus1.tms = tms;  assign bus1.tdi = tdi;  assign bus1.tdr_in = tdr_in;

   jtag_tap_param #(.IR_W(4), .NUM_TDR(3), .TDR_W(8),
                    .IDCODE_VAL(32'h1000_0001), .TLR_CLEARS_TDR(1'b0))
      u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

   jtag_tap_param #(.IR_W(4), .NUM_TDR(3), .TDR_W(8),
                    .IDCODE_VAL(32'h1000_0001), .TLR_CLEARS_TDR(1'b1))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   task automatic chk(input string tag, input logic [63:0] exp, input logic [63:0] obs);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive, clock, then sample 1 time unit after the edge.
   task automatic step(input logic t, input logic d);
      tms = t;
      tdi = d;
      @(posedge clk);
      #1;
   endtask

   // From RTI to RTI; tdo captured word goes through the scoreboard.
   task automatic scan_ir(input logic [3:0] din, input logic [3:0] exp_out);
      logic [3:0] got;
      got = '0;
      sb_q.push_back(64'(exp_out));
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);   // SEL_DR SEL_IR CAP_IR SH_IR
      chk("ir_state_shift", 64'hA, bus0.state);
      for (int i = 0; i < 4; i++) begin
         got[i] = bus0.tdo;
         step(i == 3, din[i]);
      end
      chk("ir_tdo", sb_q.pop_front(), got);
      step(1, 0); step(0, 0);                           // UPD_IR RTI
      chk("instruction", 64'(din), bus0.instruction);
   endtask

   task automatic scan_dr(input int n, input logic [31:0] din, input logic [31:0] exp_out,
                          input logic [2:0] cap, input logic [2:0] upd);
      logic [31:0] got;
      logic [3:0]  ins;
      got = '0;
      ins = bus0.instruction;
      sb_q.push_back(64'(exp_out));
      step(1, 0); step(0, 0);                           // SEL_DR CAP_DR
      chk("capture_stb", 64'(cap), bus0.capture_stb);
      step(0, 0);                                       // SH_DR
      chk("capture_stb_once", 64'h0, bus0.capture_stb);
      chk("tdo_en_shift", 64'h1, bus0.tdo_en);
      for (int i = 0; i < n; i++) begin
         got[i] = bus0.tdo;
         step(i == n - 1, din[i]);
      end
      chk("dr_tdo", sb_q.pop_front(), got);
      step(1, 0);                                       // UPD_DR
      chk("update_stb_idle", 64'h0, bus0.update_stb);
      step(0, 0);                                       // RTI
      chk("update_stb", 64'(upd), bus0.update_stb);
      step(0, 0);
      chk("update_stb_clr", 64'h0, bus0.update_stb);
      chk("dr_keeps_instr", 64'(ins), bus0.instruction);
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 64'hF, bus0.state);
      chk("rst_instr", 64'h1, bus0.instruction);
      chk("rst_tdo", 64'h0, bus0.tdo);
      chk("rst_tdo_en", 64'h0, bus0.tdo_en);
      chk("rst_tdr_out", 64'h0, bus0.tdr_out);
      chk("rst_upd_stb", 64'h0, bus0.update_stb);
      chk("rst_cap_stb", 64'h0, bus0.capture_stb);
      chk("rst_in_tlr", 64'h1, bus0.in_tlr);
      rst = 1'b0;
      step(1, 0);
      chk("tlr_hold", 64'hF, bus0.state);
      step(0, 0);
      chk("rti", 64'hC, bus0.state);
      chk("rti_in_tlr", 64'h0, bus0.in_tlr);

      // IDCODE out, LSB first
      scan_dr(32, 32'h0, 32'h1000_0001, 3'b000, 3'b000);

      // IR scan: captured 01 appears first
      scan_ir(4'b0011, 4'b0001);

      // TDR1: capture A5, load 3C
      scan_dr(8, 32'h3C, 32'hA5, 3'b010, 3'b010);
      chk("tdr1_out", 64'h3C, bus0.tdr_out[15:8]);
      chk("tdr0_keep", 64'h00, bus0.tdr_out[7:0]);
      chk("tdr2_keep", 64'h00, bus0.tdr_out[23:16]);

      // BYPASS via all-ones: one-cycle delay with leading 0
      scan_ir(4'hF, 4'b0001);
      scan_dr(4, 32'b1101, 32'b1010, 3'b000, 3'b000);
      chk("bypass_tdr_keep", 64'h00_3C_00, bus0.tdr_out);

      // TDR2 and TDR0 loads
      scan_ir(4'd4, 4'b0001);
      scan_dr(8, 32'h96, 32'h77, 3'b100, 3'b100);
      chk("tdr2_out", 64'h96, bus0.tdr_out[23:16]);
      chk("tdr2_out_d1", 64'h96, bus1.tdr_out[23:16]);
      scan_ir(4'd2, 4'b0001);
      scan_dr(8, 32'h5A, 32'h11, 3'b001, 3'b001);
      chk("tdr0_out", 64'h5A, bus0.tdr_out[7:0]);

      // tms=1 x5 from Shift-DR: passes Update-DR once with 11 shifted by one
      step(1, 0); step(0, 0); step(0, 0);
      chk("sh_dr_state", 64'h2, bus0.state);
      repeat (5) step(1, 0);
      chk("tlr5_state", 64'hF, bus0.state);
      chk("tlr5_in_tlr", 64'h1, bus0.in_tlr);
      chk("tlr5_instr", 64'h1, bus0.instruction);
      chk("tlr5_tdo_en", 64'h0, bus0.tdo_en);
      chk("tlr5_tdo", 64'h0, bus0.tdo);
      chk("tlr5_keep_d0", 64'h96_3C_08, bus0.tdr_out);
      chk("tlr5_clear_d1", 64'h0, bus1.tdr_out);
      chk("tlr5_instr_d1", 64'h1, bus1.instruction);

      // async reset during a TDR0 shift
      step(0, 0);
      scan_ir(4'd2, 4'b0001);
      step(1, 0); step(0, 0); step(0, 0);
      repeat (4) step(0, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_state", 64'hF, bus0.state);
      chk("mid_rst_tdr", 64'h0, bus0.tdr_out);
      chk("mid_rst_upd", 64'h0, bus0.update_stb);
      chk("mid_rst_instr", 64'h1, bus0.instruction);
      chk("mid_rst_tdo_en", 64'h0, bus0.tdo_en);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1, 0);
      step(1, 0);
      chk("post_rst_upd", 64'h0, bus0.update_stb);
      chk("post_rst_tdr", 64'h0, bus0.tdr_out);
      chk("post_rst_state", 64'hF, bus0.state);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
